// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative AES-256 decryptor.
// Contents: FSM state enum, round-constant table, GF(2^8) helpers
// (xtime, multiply by 09/0b/0d/0e, generic multiply, inverse) and the
// forward / inverse S-box and InvMixColumns column functions.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_READY,
        ST_DEC,
        ST_DONE
    } fsm_e;

    // rcon[i/2] for even key-expansion steps i = 2..14; entry 0 unused.
    localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                         8'h08, 8'h10, 8'h20, 8'h40};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // Column byte 0 is [31:24].
    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
// Ports: in_byte (8) -> out_byte (8).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    assign out_byte = sbox_inv(in_byte);
endmodule

// File: rtl/aes_sbox4.sv
// Registered four-byte forward S-box (SubWord); result appears one clock
// after word_in is presented.
// Ports: clk, rst_n, word_in (32) -> sub_word (32, registered).
module aes_sbox4
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    output logic [31:0] sub_word
);
    logic [31:0] sub_d, sub_q;

    always_comb begin
        sub_d = {sbox_fwd(word_in[31:24]), sbox_fwd(word_in[23:16]),
                 sbox_fwd(word_in[15:8]),  sbox_fwd(word_in[7:0])};
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= '0;
        else        sub_q <= sub_d;
    end

    assign sub_word = sub_q;
endmodule

// File: rtl/aes_256_dec_iter.sv
// Iterative AES-256 decryptor (InvCipher). A key handshake stores round
// keys 0/1 and expands 2..14 in 13 two-cycle steps through one registered
// SubWord unit; each ciphertext then takes 14 round cycles and the
// plaintext is held until consumed.
// Ports: clk, rst_n; key_valid/key_ready/key[255:0];
//        in_valid/in_ready/state[127:0] (ciphertext);
//        out_valid/out_ready/out[127:0] (plaintext).
module aes_256_dec_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);
    fsm_e         fsm_d, fsm_q;
    logic         key_ready_d, key_ready_q;
    logic         in_ready_d, in_ready_q;
    logic         out_valid_d, out_valid_q;
    logic [127:0] out_d, out_q;
    logic [127:0] s_d, s_q;
    logic [3:0]   rnd_d, rnd_q;
    logic [3:0]   step_d, step_q;
    logic         phase_d, phase_q;

    logic [127:0] rk_q [15];
    logic         rk_load_key;
    logic         rk_we;

    // ---------------- key expansion datapath ----------------
    logic [3:0]   idx_m1, idx_m2;
    logic [31:0]  prev_w3, sbox_in, sub_w, t_w;
    logic [127:0] pp, rk_new;

    assign idx_m1  = step_q - 4'd1;
    assign idx_m2  = step_q - 4'd2;
    assign prev_w3 = rk_q[idx_m1][31:0];
    assign pp      = rk_q[idx_m2];
    // Even steps rotate before SubWord; rotation commutes with the bytewise S-box.
    assign sbox_in = step_q[0] ? prev_w3 : {prev_w3[23:0], prev_w3[31:24]};

    aes_sbox4 u_sbox4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .word_in  (sbox_in),
        .sub_word (sub_w)
    );

    assign t_w = step_q[0] ? sub_w : sub_w ^ {RCON[step_q[3:1]], 24'h0};
    assign rk_new[127:96] = pp[127:96] ^ t_w;
    assign rk_new[95:64]  = pp[95:64]  ^ rk_new[127:96];
    assign rk_new[63:32]  = pp[63:32]  ^ rk_new[95:64];
    assign rk_new[31:0]   = pp[31:0]   ^ rk_new[63:32];

    // ---------------- inverse round datapath ----------------
    logic [127:0] isr, isb, ark, imc;

    // Byte k = 4*col + row sits at [127-8k -: 8]; row r shifts right by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
        for (genvar r = 0; r < 4; r++) begin : g_isr_row
            assign isr[127-8*(4*c+r) -: 8] = s_q[127-8*(4*((c+4-r)%4)+r) -: 8];
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_isb
        aes_inv_sbox u_inv_sbox (
            .in_byte  (isr[8*g +: 8]),
            .out_byte (isb[8*g +: 8])
        );
    end

    assign ark = isb ^ rk_q[rnd_q];

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[32*c +: 32] = inv_mix_column(ark[32*c +: 32]);
    end

    // ---------------- control ----------------
    always_comb begin
        // NOTE: every next-state value defaults to its current value so no path infers a latch.
        fsm_d       = fsm_q;
        key_ready_d = key_ready_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        s_d         = s_q;
        rnd_d       = rnd_q;
        step_d      = step_q;
        phase_d     = phase_q;
        rk_load_key = 1'b0;
        rk_we       = 1'b0;

        case (fsm_q)
            ST_IDLE, ST_READY: begin
                // Key wins over ciphertext when both are offered in READY.
                if (key_valid) begin
                    fsm_d       = ST_KEYEXP;
                    key_ready_d = 1'b0;
                    in_ready_d  = 1'b0;
                    rk_load_key = 1'b1;
                    step_d      = 4'd2;
                    phase_d     = 1'b0;
                end else if (fsm_q == ST_READY && in_valid) begin
                    fsm_d       = ST_DEC;
                    key_ready_d = 1'b0;
                    in_ready_d  = 1'b0;
                    s_d         = state ^ rk_q[14];
                    rnd_d       = 4'd13;
                end
            end
            ST_KEYEXP: begin
                // step 15 is the settle cycle after rk14 is written.
                if (step_q == 4'd15) begin
                    fsm_d       = ST_READY;
                    key_ready_d = 1'b1;
                    in_ready_d  = 1'b1;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    rk_we   = 1'b1;
                    phase_d = 1'b0;
                    step_d  = step_q + 4'd1;
                end
            end
            ST_DEC: begin
                if (rnd_q != 4'd0) begin
                    s_d   = imc;
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    out_d       = ark;
                    out_valid_d = 1'b1;
                    fsm_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    key_ready_d = 1'b1;
                    fsm_d       = ST_READY;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            key_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            s_q         <= '0;
            rnd_q       <= '0;
            step_q      <= '0;
            phase_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            key_ready_q <= key_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            s_q         <= s_d;
            rnd_q       <= rnd_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
        end
    end

    // NOTE: the round-key file has no reset; the FSM never reads it before a key load fills it.
    always_ff @(posedge clk) begin
        if (rk_load_key) begin
            rk_q[0] <= key[255:128];
            rk_q[1] <= key[127:0];
        end else if (rk_we) begin
            rk_q[step_q] <= rk_new;
        end
    end

    assign key_ready = key_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule

// File: tb/tb_aes_256_dec_iter.sv
// Directed bench for aes_256_dec_iter: FIPS-197 C.3 and zero-key vectors,
// key-expansion timing, backpressure, mid-run reset, key/ciphertext
// arbitration and an encrypt/decrypt round trip against a reference cipher.
module tb_aes_256_dec_iter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid, key_ready;
    logic [255:0] key;
    logic         in_valid, in_ready;
    logic [127:0] state;
    logic         out_valid, out_ready;
    logic [127:0] out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

    logic [7:0] sbox_t [256];

    aes_256_dec_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference cipher ----------------
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return gmul_ref(a, 8'h02);
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul_ref(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] enc_ref(input logic [255:0] k, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] rk, res;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        rk = {w[0], w[1], w[2], w[3]};
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ rk[127-8*j -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int j = 0; j < 16; j++) s[j] = sbox_t[s[j]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    u[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++) begin
                if (r < 14) begin
                    s[4*c]   = xt(u[4*c]) ^ xt(u[4*c+1]) ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+1] = u[4*c] ^ xt(u[4*c+1]) ^ xt(u[4*c+2]) ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+2] = u[4*c] ^ u[4*c+1] ^ xt(u[4*c+2]) ^ xt(u[4*c+3]) ^ u[4*c+3];
                    s[4*c+3] = xt(u[4*c]) ^ u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ xt(u[4*c+3]);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = u[4*c+row];
                end
            end
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[127-8*j -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    // ---------------- stimulus tasks ----------------
    // Loads a key; optionally offers a ciphertext on the same edge (it must lose).
    task automatic load_key(input logic [255:0] k, input logic with_in, input string tag);
        int n;
        n = 0;
        key = k;
        key_valid = 1'b1;
        if (with_in) begin
            in_valid = 1'b1;
            state = CT_C3;
        end
        while (!key_ready && n < 100) begin tick(); n++; end
        check({tag, "_key_ready"}, 128'(key_ready), 128'd1);
        tick();
        key_valid = 1'b0;
        in_valid = 1'b0;
        check({tag, "_busy"}, {126'd0, key_ready, in_ready}, 128'd0);
        for (int e = 1; e <= 27; e++) begin
            tick();
            if (e == 26) check({tag, "_in_ready_e26"}, 128'(in_ready), 128'd0);
        end
        check({tag, "_in_ready_e27"}, 128'(in_ready), 128'd1);
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int n;
        n = 0;
        state = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin tick(); n++; end
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check({tag, "_latency"}, 128'(n), 128'd14);
        check({tag, "_out"}, out, pt);
        tick();
        check({tag, "_released"}, {126'd0, out_valid, in_ready}, 128'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        key_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        key = '0;
        state = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [127:0] held;
        logic [255:0] rk;
        logic [127:0] pt, ct;
        int n;

        build_sbox();
        rst_n = 1'b0;
        key_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        key = '0;
        state = '0;
        #22;
        check("reset_key_ready", 128'(key_ready), 128'd1);
        check("reset_in_ready", 128'(in_ready), 128'd0);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out", out, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Ciphertext offered with no key loaded is never taken.
        state = CT_C3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("nokey_in_ready", 128'(in_ready), 128'd0);
        check("nokey_out_valid", 128'(out_valid), 128'd0);
        in_valid = 1'b0;

        // FIPS-197 C.3
        load_key(KEY_C3, 1'b0, "c3_key");
        decrypt(CT_C3, PT_C3, "c3");

        // Key reload in READY while a ciphertext is also offered: key wins.
        load_key(256'd0, 1'b1, "zero_key");
        decrypt(CT_Z, 128'd0, "zero");

        // Backpressure on the plaintext channel.
        load_key(KEY_C3, 1'b0, "bp_key");
        out_ready = 1'b0;
        state = CT_C3;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        tick();
        state = CT_Z;            // keep offering a different block; must be ignored
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("bp_latency", 128'(n), 128'd14);
        held = out;
        check("bp_out", held, PT_C3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {out_valid, in_ready, out}, {1'b1, 1'b0, PT_C3});
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_release", {126'd0, out_valid, in_ready}, 128'd1);
        tick();
        check("bp_one_hs", {125'd0, out_valid, in_ready, key_ready}, 128'd3);
        check("bp_out_kept", out, PT_C3);

        // Round trip, back-to-back blocks under one random key.
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        load_key(rk, 1'b0, "rt_key");
        for (int b = 0; b < 40; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = enc_ref(rk, pt);
            state = ct;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 100) begin tick(); n++; end
            check("rt_in_ready", 128'(in_ready), 128'd1);
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 40) begin tick(); n++; end
            check("rt_latency", 128'(n), 128'd14);
            check("rt_out", out, pt);
        end
        tick();

        // Reset in the middle of decryption (round key 6 in use).
        state = CT_C3;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'd0);
        check("rst_mid_key_ready", 128'(key_ready), 128'd1);
        check("rst_mid_in_ready", 128'(in_ready), 128'd0);
        apply_reset();
        check("rst_mid_no_out", 128'(out_valid), 128'd0);
        load_key(KEY_C3, 1'b0, "rst_key");
        decrypt(CT_C3, PT_C3, "rst_c3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
